// File: rtl/rcv_drain_ctrl.sv
// Receive drain controller: hands bytes from a UART receiver into a small FIFO
// and counts receiver error events.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rx_data           byte offered by the receiver
//   data_ready        receiver holds a valid byte
//   framing_error     receiver framing error flag (level)
//   overrun_error     receiver overrun flag (level)
//   data_read         one-cycle acknowledge back to the receiver
//   out_data          FIFO head byte (don't-care while out_valid=0)
//   out_valid         FIFO non-empty
//   out_ready         consumer accepts the head byte
//   fifo_count        current occupancy, 0..DEPTH
//   frame_err_cnt     saturating count of framing_error rising edges
//   overrun_cnt       saturating count of overrun_error rising edges
module rcv_drain_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     data_ready,
  input  logic                     framing_error,
  input  logic                     overrun_error,
  output logic                     data_read,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         frame_err_cnt,
  output logic [CNT_W-1:0]         overrun_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

  typedef enum logic [1:0] {StIdle, StAck, StRelease} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop, full;
  logic            fe_q, ov_q;
  logic [CNT_W-1:0] fe_cnt_q, ov_cnt_q;

  // Full is judged on the pre-edge occupancy, so a same-cycle pop never
  // makes room for a push.
  assign full      = (count_q == DepthCnt);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[head_q];
  assign data_read = (state_q == StAck);
  assign fifo_count    = count_q;
  assign frame_err_cnt = fe_cnt_q;
  assign overrun_cnt   = ov_cnt_q;

  // Capture in IDLE, acknowledge for one cycle, then wait in RELEASE until the
  // receiver drops data_ready so the same byte is never captured twice.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (data_ready && !full) begin
          push    = 1'b1;
          state_d = StAck;
        end
      end
      StAck:     state_d = StRelease;
      StRelease: if (!data_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= rx_data;
  end

  // Rising-edge event counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      fe_cnt_q <= '0;
      ov_cnt_q <= '0;
    end else begin
      fe_q <= framing_error;
      ov_q <= overrun_error;
      if (framing_error && !fe_q && (fe_cnt_q != '1)) fe_cnt_q <= fe_cnt_q + 1'b1;
      if (overrun_error && !ov_q && (ov_cnt_q != '1)) ov_cnt_q <= ov_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Bench for rcv_drain_ctrl: a queue-based model checked every cycle, plus
// directed scenarios with literal expectations. A second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_rcv_drain_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       data_ready = 1'b0;
  logic       framing_error = 1'b0;
  logic       overrun_error = 1'b0;
  logic       out_ready = 1'b0;

  logic       data_read, out_valid;
  logic [7:0] out_data;
  logic [2:0] fifo_count;
  logic [7:0] frame_err_cnt, overrun_cnt;

  logic       s_data_read, s_out_valid;
  logic [7:0] s_out_data;
  logic [2:0] s_fifo_count;
  logic [1:0] s_frame_err_cnt, s_overrun_cnt;

  always #5 tb_clk = ~tb_clk;

  rcv_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(tb_clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count),
    .frame_err_cnt(frame_err_cnt), .overrun_cnt(overrun_cnt)
  );

  rcv_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(tb_clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(s_data_read), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .fifo_count(s_fifo_count),
    .frame_err_cnt(s_frame_err_cnt), .overrun_cnt(s_overrun_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit  m_live = 0;
  bit  m_read = 0;   // acknowledge expected this cycle
  bit  m_hold = 0;   // byte taken, waiting for receiver to drop data_ready
  bit  m_full, m_new;
  bit  m_fe_prev = 0, m_ov_prev = 0;
  int  m_fe = 0, m_ov = 0, m_fe_s = 0, m_ov_s = 0;

  always @(posedge tb_clk) begin
    if (rst) begin
      mq.delete();
      m_read = 0; m_hold = 0; m_fe_prev = 0; m_ov_prev = 0;
      m_fe = 0; m_ov = 0; m_fe_s = 0; m_ov_s = 0;
      m_live = 1;
    end else if (m_live) begin
      m_full = (mq.size() >= DEPTH);
      m_new  = 0;
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (m_read)      m_hold = 1;
      else if (m_hold) m_hold = data_ready;
      else if (data_ready && !m_full) begin
        mq.push_back(rx_data);
        m_new = 1;
      end
      m_read = m_new;
      if (framing_error && !m_fe_prev) begin
        if (m_fe < 255) m_fe++;
        if (m_fe_s < 3) m_fe_s++;
      end
      if (overrun_error && !m_ov_prev) begin
        if (m_ov < 255) m_ov++;
        if (m_ov_s < 3) m_ov_s++;
      end
      m_fe_prev = framing_error;
      m_ov_prev = overrun_error;
    end
  end

  // ---------------- per-cycle compare ----------------
  int         rd_pulses = 0;
  int         max_count = 0;
  logic [7:0] pop_log[$];

  always @(negedge tb_clk) begin
    if (m_live) begin
      check("data_read", 32'(data_read), 32'(m_read));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
      check("frame_err_cnt", 32'(frame_err_cnt), 32'(m_fe));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ov));
      check("sat_frame_err_cnt", 32'(s_frame_err_cnt), 32'(m_fe_s));
      check("sat_overrun_cnt", 32'(s_overrun_cnt), 32'(m_ov_s));
      if (data_read === 1'b1) rd_pulses++;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (out_valid === 1'b1 && out_ready && !rst) pop_log.push_back(out_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge tb_clk);
    #2;
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (data_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(data_read), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data    = b;
    data_ready = 1'b1;
    tick();
    wait_read("send_ack");
    data_ready = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic check_log(input string name, input logic [7:0] first, input int len);
    check({name, "_len"}, 32'(pop_log.size()), 32'(len));
    for (int i = 0; i < len && i < pop_log.size(); i++)
      check({name, "_order"}, 32'(pop_log[i]), 32'(first + 8'(i)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int p0;

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_read", 32'(data_read), 32'd0);
    check("rst_frame", 32'(frame_err_cnt), 32'd0);

    // Single byte held high: one capture, one acknowledge.
    tick();
    rx_data    = 8'hD5;
    data_ready = 1'b1;
    p0         = rd_pulses;
    tick();
    check("lat_read", 32'(data_read), 32'd1);
    check("lat_valid", 32'(out_valid), 32'd1);
    tick();
    check("lat_read_drop", 32'(data_read), 32'd0);
    repeat (5) tick();
    data_ready = 1'b0;
    repeat (2) tick();
    check("single_pulses", 32'(rd_pulses - p0), 32'd1);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_data", 32'(out_data), 32'hD5);
    pop_log.delete();
    drain();
    check_log("single_pop", 8'hD5, 1);

    // Fill to full, fifth byte waits until space frees.
    pop_log.delete();
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    check("fill_count", 32'(fifo_count), 32'd4);
    tick();
    rx_data    = 8'h05;
    data_ready = 1'b1;
    p0         = rd_pulses;
    repeat (4) tick();
    check("full_no_read", 32'(rd_pulses - p0), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    wait_read("full_late_ack");
    data_ready = 1'b0;
    drain();
    check_log("fill_pop", 8'h01, 5);

    // Push and pop together at occupancy 2.
    pop_log.delete();
    send_byte(8'h10);
    send_byte(8'h11);
    tick();
    rx_data    = 8'h12;
    data_ready = 1'b1;
    out_ready  = 1'b1;
    tick();
    check("pp2_count", 32'(fifo_count), 32'd2);
    check("pp2_read", 32'(data_read), 32'd1);
    out_ready  = 1'b0;
    data_ready = 1'b0;
    tick();
    drain();
    check_log("pp2_pop", 8'h10, 3);

    // Push request and pop together while full: push waits a cycle.
    pop_log.delete();
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    tick();
    rx_data    = 8'h24;
    data_ready = 1'b1;
    out_ready  = 1'b1;
    tick();
    check("pp4_count", 32'(fifo_count), 32'd3);
    check("pp4_no_read", 32'(data_read), 32'd0);
    out_ready = 1'b0;
    tick();
    check("pp4_count_late", 32'(fifo_count), 32'd4);
    check("pp4_read_late", 32'(data_read), 32'd1);
    data_ready = 1'b0;
    tick();
    drain();
    check_log("pp4_pop", 8'h20, 5);

    // Error counting and saturation.
    for (int i = 0; i < 3; i++) begin
      tick(); framing_error = 1'b1;
      tick(); framing_error = 1'b0;
    end
    overrun_error = 1'b1;
    repeat (10) tick();
    overrun_error = 1'b0;
    repeat (2) tick();
    check("err_frame3", 32'(frame_err_cnt), 32'd3);
    check("err_overrun1", 32'(overrun_cnt), 32'd1);
    check("sat_overrun1", 32'(s_overrun_cnt), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); framing_error = 1'b1;
      tick(); framing_error = 1'b0;
    end
    repeat (2) tick();
    check("err_frame5", 32'(frame_err_cnt), 32'd5);
    check("sat_frame_hold", 32'(s_frame_err_cnt), 32'd3);

    // Reset while acknowledging with three bytes stored.
    send_byte(8'h30);
    send_byte(8'h31);
    tick();
    rx_data    = 8'h33;
    data_ready = 1'b1;
    tick();
    check("mid_ack_read", 32'(data_read), 32'd1);
    check("mid_ack_count", 32'(fifo_count), 32'd3);
    rst        = 1'b1;
    data_ready = 1'b0;
    tick();
    check("rst_mid_read", 32'(data_read), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_frame", 32'(frame_err_cnt), 32'd0);
    check("rst_mid_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_mid_sat", 32'(s_frame_err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Streaming with the consumer always ready: pointers wrap, occupancy <= 1.
    pop_log.delete();
    max_count = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i));
    repeat (3) tick();
    out_ready = 1'b0;
    check_log("wrap_pop", 8'h40, 10);
    check("wrap_max_count", 32'(max_count), 32'd1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
